// File: rtl/master_0_st_channel_arbiter_if.sv
// Avalon-ST bundle for master_0_st_channel_arbiter: NUM_IN input streams plus one channelized output.
// The arbiter uses the master modport; sources and the downstream sink drive the slave side.
interface master_0_st_channel_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8,
  parameter int CHAN_W = 8
) ();
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHAN_W-1:0]        out_channel;

  modport master (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
  );

  modport slave (
    output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
  );
endinterface

// File: rtl/master_0_st_channel_arbiter.sv
// Packet-level round-robin merge of NUM_IN Avalon-ST byte streams onto one channelized stream.
// Optional idle-grant watchdog is built when ST_ARB_WATCHDOG_EN is defined.
module master_0_st_channel_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 8,
  parameter int CHAN_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  master_0_st_channel_arbiter_if.master  bus,
  output logic                           drop_err,
  output logic                           timeout_err
);
  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_IN-1:0]  req, drop, ready;
  logic               accept, release_pkt, timeout_hit;
  logic               sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0]  sel_data;
  logic               drop_err_q, timeout_err_q;
  logic               vld_p1, sop_p1, eop_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [CHAN_W-1:0]  chan_p1;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_IN-1:0] r,
                                               input logic [IDX_W-1:0]  ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (!found && r[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    return (int'(g) == NUM_IN - 1) ? '0 : g + IDX_W'(1);
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid = bus.in_valid[i];
        sel_sop   = bus.in_startofpacket[i];
        sel_eop   = bus.in_endofpacket[i];
        sel_data  = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    req         = bus.in_valid & bus.in_startofpacket;
    drop        = '0;
    ready       = '0;
    accept      = 1'b0;
    release_pkt = 1'b0;
    if (state_q == IDLE) begin
      // Non-SOP beats are swallowed here; SOP beats wait for the grant.
      drop  = bus.in_valid & ~bus.in_startofpacket;
      ready = drop;
      if (|req) begin
        state_d = BUSY;
        grant_d = rr_pick(req, rr_ptr_q);
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant_q == IDX_W'(i)) ready[i] = bus.out_ready | ~vld_p1;
      end
      accept      = sel_valid & (bus.out_ready | ~vld_p1);
      release_pkt = (accept & sel_eop) | timeout_hit;
      if (release_pkt) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next(grant_q);
      end
    end
  end

`ifdef ST_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt_q;

  assign timeout_hit = (state_q == BUSY) && !sel_valid && (wd_cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else if (state_q != BUSY || accept || timeout_hit) begin
      wd_cnt_q <= '0;
    end else if (!sel_valid) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      drop_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      drop_err_q    <= |drop;
      timeout_err_q <= timeout_hit;
    end
  end

  // Stage p1: output register, holds while stalled downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      chan_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      sop_p1  <= sel_sop;
      eop_p1  <= sel_eop;
      chan_p1 <= CHAN_W'(grant_q);
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready          = reset_n ? ready : '0;
  assign bus.out_valid         = vld_p1;
  assign bus.out_data          = data_p1;
  assign bus.out_startofpacket = sop_p1;
  assign bus.out_endofpacket   = eop_p1;
  assign bus.out_channel       = chan_p1;
  assign drop_err              = drop_err_q;
  assign timeout_err           = timeout_err_q;
endmodule

// File: tb/tb_master_0_st_channel_arbiter.sv
// Directed bench for master_0_st_channel_arbiter: single packet, discard, watchdog/held grant,
// reset mid-packet, round-robin fairness and backpressure.
module tb_master_0_st_channel_arbiter;
  localparam int NUM_IN  = 4;
  localparam int DATA_W  = 8;
  localparam int CHAN_W  = 8;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic drop_err, timeout_err;
  int   checks = 0;
  int   errors = 0;
  int   plen[4];
  int   nb[4];
  logic [15:0] rdy_pat;
  logic [17:0] exp_q[$];

  master_0_st_channel_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .CHAN_W(CHAN_W)) bus ();

  master_0_st_channel_arbiter #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .CHAN_W(CHAN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .drop_err(drop_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input bit v, input logic [7:0] d, input bit sop, input bit eop);
    bus.in_valid[i]                  = v;
    bus.in_data[i*DATA_W +: DATA_W]  = d;
    bus.in_startofpacket[i]          = sop;
    bus.in_endofpacket[i]            = eop;
  endtask

  task automatic clr_in();
    bus.in_valid         = '0;
    bus.in_data          = '0;
    bus.in_startofpacket = '0;
    bus.in_endofpacket   = '0;
  endtask

  function automatic logic [17:0] w(input bit s, input bit e, input int ch, input logic [7:0] d);
    return {s, e, 8'(ch), d};
  endfunction

  function automatic logic [17:0] out_word();
    return {bus.out_startofpacket, bus.out_endofpacket, bus.out_channel, bus.out_data};
  endfunction

  // Drives packetised sources from plen/nb, applies rdy_pat to out_ready, checks against exp_q.
  task automatic run(input string tag, input int max_cycles);
    int          k[4];
    int          got;
    logic [3:0]  hs_in;
    bit          stall;
    logic [17:0] held;
    k   = '{default: 0};
    got = 0;
    for (int c = 0; c < max_cycles && got < exp_q.size(); c++) begin
      for (int i = 0; i < 4; i++) begin
        if (k[i] < nb[i])
          set_in(i, 1'b1, 8'(i*16 + k[i]), (k[i] % plen[i]) == 0, (k[i] % plen[i]) == plen[i] - 1);
        else
          set_in(i, 1'b0, 8'h00, 1'b0, 1'b0);
      end
      bus.out_ready = rdy_pat[c % 16];
      #1;
      stall = bus.out_valid && !bus.out_ready;
      held  = out_word();
      if (stall) chk({tag, "_stall_ready"}, 32'(bus.in_ready), 32'd0);
      hs_in = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        chk({tag, "_beat"}, 32'(out_word()), 32'(exp_q[got]));
        got++;
      end
      tick();
      for (int i = 0; i < 4; i++) if (hs_in[i]) k[i]++;
      if (stall) begin
        chk({tag, "_hold_word"}, 32'(out_word()), 32'(held));
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      end
    end
    chk({tag, "_count"}, 32'(got), 32'(exp_q.size()));
    clr_in();
    bus.out_ready = 1'b1;
  endtask

  int ord[12] = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};

  initial begin
    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    clr_in();
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_word", 32'(out_word()), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single 3-beat packet on input 2
    set_in(2, 1'b1, 8'hA1, 1'b1, 1'b0);
    #1;
    chk("sp_ready_arb", 32'(bus.in_ready), 32'd0);
    tick();
    chk("sp_valid_c1", 32'(bus.out_valid), 32'd0);
    chk("sp_ready_grant", 32'(bus.in_ready), 32'b0100);
    tick();
    chk("sp_valid_c2", 32'(bus.out_valid), 32'd1);
    chk("sp_beat1", 32'(out_word()), 32'(w(1, 0, 2, 8'hA1)));
    set_in(2, 1'b1, 8'hA2, 1'b0, 1'b0);
    tick();
    chk("sp_beat2", 32'(out_word()), 32'(w(0, 0, 2, 8'hA2)));
    set_in(2, 1'b1, 8'hA3, 1'b0, 1'b1);
    tick();
    chk("sp_beat3", 32'(out_word()), 32'(w(0, 1, 2, 8'hA3)));
    clr_in();
    tick();
    chk("sp_drain", 32'(bus.out_valid), 32'd0);

    // Discard on input 0 while input 2 arbitrates with a single-beat packet
    set_in(0, 1'b1, 8'h55, 1'b0, 1'b0);
    set_in(2, 1'b1, 8'h77, 1'b1, 1'b1);
    #1;
    chk("dc_ready_idle", 32'(bus.in_ready), 32'b0001);
    tick();
    chk("dc_drop_pulse", 32'(drop_err), 32'd1);
    chk("dc_no_out", 32'(bus.out_valid), 32'd0);
    set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("dc_ready_grant", 32'(bus.in_ready), 32'b0100);
    tick();
    chk("dc_drop_once", 32'(drop_err), 32'd0);
    chk("dc_single_beat", 32'(out_word()), 32'(w(1, 1, 2, 8'h77)));
    chk("dc_single_valid", 32'(bus.out_valid), 32'd1);
    clr_in();
    tick();

    // Input 3 stalls after its SOP beat while input 0 waits with a SOP
    set_in(3, 1'b1, 8'h3A, 1'b1, 1'b0);
    tick();
    chk("wd_ready_grant", 32'(bus.in_ready), 32'b1000);
    tick();
    chk("wd_beat", 32'(out_word()), 32'(w(1, 0, 3, 8'h3A)));
    chk("wd_beat_valid", 32'(bus.out_valid), 32'd1);
    clr_in();
    set_in(0, 1'b1, 8'h0B, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("wd_no_early", 32'(timeout_err), 32'd0);
    chk("wd_still_held", 32'(bus.in_ready), 32'b1000);
    tick();
`ifdef ST_ARB_WATCHDOG_EN
    chk("wd_pulse", 32'(timeout_err), 32'd1);
    chk("wd_idle_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("wd_pulse_once", 32'(timeout_err), 32'd0);
    chk("wd_regrant", 32'(bus.in_ready), 32'b0001);
    tick();
    chk("wd_next_beat", 32'(out_word()), 32'(w(1, 1, 0, 8'h0B)));
`else
    chk("wd_tied", 32'(timeout_err), 32'd0);
    chk("wd_held", 32'(bus.in_ready), 32'b1000);
    set_in(3, 1'b1, 8'h3C, 1'b0, 1'b1);
    tick();
    chk("wd_eop", 32'(out_word()), 32'(w(0, 1, 3, 8'h3C)));
    set_in(3, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("wd_regrant", 32'(bus.in_ready), 32'b0001);
    tick();
    chk("wd_next_beat", 32'(out_word()), 32'(w(1, 1, 0, 8'h0B)));
`endif
    clr_in();
    tick();

    // Reset asserted after beat 2 of a 5-beat packet on input 1
    set_in(1, 1'b1, 8'hE0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rm_beat1", 32'(out_word()), 32'(w(1, 0, 1, 8'hE0)));
    set_in(1, 1'b1, 8'hE1, 1'b0, 1'b0);
    tick();
    chk("rm_beat2", 32'(out_word()), 32'(w(0, 0, 1, 8'hE1)));
    set_in(1, 1'b1, 8'hE2, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rm_valid", 32'(bus.out_valid), 32'd0);
    chk("rm_word", 32'(out_word()), 32'd0);
    chk("rm_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rm_errs", 32'({drop_err, timeout_err}), 32'd0);
    tick();
    chk("rm_hold_valid", 32'(bus.out_valid), 32'd0);
    chk("rm_hold_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;
    set_in(1, 1'b1, 8'hF0, 1'b1, 1'b1);
    #1;
    chk("rm_ready_arb", 32'(bus.in_ready), 32'd0);
    tick();
    chk("rm_grant", 32'(bus.in_ready), 32'b0010);
    tick();
    chk("rm_fresh_beat", 32'(out_word()), 32'(w(1, 1, 1, 8'hF0)));
    chk("rm_fresh_valid", 32'(bus.out_valid), 32'd1);
    clr_in();
    tick();
    chk("rm_drain", 32'(bus.out_valid), 32'd0);

    // Fairness from reset: inputs 0, 1, 3 each hold two 2-beat packets
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    plen    = '{2, 2, 2, 2};
    nb      = '{4, 4, 0, 4};
    rdy_pat = 16'hFFFF;
    exp_q.delete();
    for (int j = 0; j < 12; j++)
      exp_q.push_back(w((j % 2) == 0, (j % 2) == 1, ord[j], 8'(ord[j]*16 + (j/6)*2 + (j % 2))));
    run("fair", 80);
    tick();

    // Backpressure: 4-beat packet on input 1 with out_ready dropping for two cycles
    plen    = '{4, 4, 4, 4};
    nb      = '{0, 4, 0, 0};
    rdy_pat = 16'hFFE7;
    exp_q.delete();
    for (int j = 0; j < 4; j++)
      exp_q.push_back(w(j == 0, j == 3, 1, 8'(16 + j)));
    run("bp", 40);
    tick();
    chk("bp_drain", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/master_0_st_channel_arbiter.md
# master_0_st_channel_arbiter

Packet-level round-robin arbiter that merges NUM_IN Avalon-ST byte streams onto one channelized Avalon-ST output. A grant is held from startofpacket to endofpacket, so packets are never interleaved. Each forwarded beat is tagged on out_channel with the winning input index. The block sits in front of the master_0 channel adapter path and lets several byte sources share the single packet/channel link toward the host-side master.

## Interface
- NUM_IN, 4: number of input streams (2..8).
- DATA_W, 8: symbol width.
- CHAN_W, 8: out_channel width; must satisfy 2^CHAN_W >= NUM_IN.
- TIMEOUT, 255: idle-cycle limit for the watchdog (see Configuration), 1..65535.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_IN  per-input valid.
- in_ready  out  NUM_IN  per-input ready.
- in_data  in  NUM_IN*DATA_W  input i occupies bits [i*DATA_W +: DATA_W].
- in_startofpacket  in  NUM_IN  per-input SOP.
- in_endofpacket  in  NUM_IN  per-input EOP.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  registered data.
- out_startofpacket  out  1  registered SOP.
- out_endofpacket  out  1  registered EOP.
- out_channel  out  CHAN_W  index of the input that sourced the beat.
- drop_err  out  1  one-cycle pulse when a non-SOP beat is discarded while IDLE.
- timeout_err  out  1  one-cycle pulse on a watchdog release (0 when the macro is absent).

## Operation
- States:
  - IDLE: no grant is held.
  - BUSY: grant g is held.
- rr_ptr (log2 NUM_IN bits) holds the highest-priority index.
- IDLE arbitration:
  - Requester set R = in_valid & in_startofpacket.
  - If R is non-zero, the first set bit at or after rr_ptr (wrapping) is registered as g, and the state goes to BUSY.
  - No beat is accepted in the arbitration cycle.
- IDLE discard:
  - Any input with in_valid=1 and in_startofpacket=0 gets in_ready=1 and its beat is discarded.
  - drop_err pulses the next cycle when one or more beats are discarded.
  - Discard and arbitration of other inputs happen in the same cycle.
- BUSY:
  - in_ready[g] = out_ready | ~out_valid.
  - All other in_ready bits are 0.
  - An accepted beat (in_valid[g] & in_ready[g]) loads the output register with data/SOP/EOP and out_channel = g zero-extended.
- Packet end: when the accepted beat has EOP, the state goes to IDLE and rr_ptr = (g+1) mod NUM_IN.
- A single-beat packet (SOP and EOP both set) follows the same flow.
- A SOP beat arriving mid-packet on g is forwarded unchanged; the arbiter performs no packet repair.
- Output register:
  - out_valid clears when out_ready=1 and no new beat loads.
  - Data holds stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - State IDLE, rr_ptr 0.
  - out_valid, out_data, out_startofpacket, out_endofpacket, out_channel all 0.
  - drop_err and timeout_err 0.
  - in_ready all 0.
- Reset asserted mid-packet aborts immediately, with no EOP emitted.
- Latency:
  - SOP valid at cycle 0 while IDLE leads to grant at cycle 1, first beat accepted at cycle 1, and out_valid at cycle 2.
  - Steady-state throughput is 1 beat/cycle with out_ready held high.
- Packet gap: an EOP accepted at cycle N returns to IDLE at N+1; the next grant's first beat is accepted no earlier than N+2.
- Backpressure: out_ready low with out_valid high drives in_ready[g] low in the same cycle (combinational path).

## Configuration
- ST_ARB_WATCHDOG_EN defined:
  - In BUSY, a counter increments on each cycle with in_valid[g]=0 and clears on an accepted beat.
  - When the count reaches TIMEOUT, the state goes to IDLE, rr_ptr advances past g, and timeout_err pulses one cycle.
  - Already-registered output beats are still delivered.
- ST_ARB_WATCHDOG_EN undefined: no counter is built, the grant is held indefinitely, and timeout_err is tied to 0.

## Test plan
- Single packet: input 2 sends 3 beats 0xA1, 0xA2, 0xA3 with SOP on the first and EOP on the last, out_ready=1. Output shows the same 3 beats with out_channel=2; first out_valid appears 2 cycles after the SOP is presented.
- Fairness: inputs 0, 1 and 3 all hold 2-beat packets from reset. Output channel order is 0, 1, 3, 0, 1, 3 with no interleaving within a packet.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-beat packet on input 1. No beat is lost or duplicated, and out_data is stable while stalled.
- Discard: input 0 presents 0x55 without SOP while IDLE. in_ready[0]=1, drop_err pulses once, and out_valid stays 0.
- Watchdog (macro defined, TIMEOUT=4): input 3 sends the SOP beat, then holds in_valid low. timeout_err pulses after 4 idle cycles, and a pending SOP on input 0 is then granted.
- Reset mid-packet: reset_n goes low after beat 2 of 5. All outputs read 0 during reset; after release a fresh SOP on input 1 is granted normally.
